// File: rtl/mc_control_fsm.sv
// Multi-cycle sequencing controller for the MIPS core: FETCH/DECODE/EXEC/MEM/WB plus MDU wait and exception entry.
// Optional feature macro RI_EXC_EN: unrecognised encodings raise a reserved-instruction exception (cause 10).
module mc_control_fsm #(
    parameter int IMEM_WAIT  = 0,
    parameter int DMEM_WAIT  = 0,
    parameter int MDU_LAT    = 32,
    parameter int EXC_CODE_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            op,
    input  logic [5:0]            func,
    input  logic [4:0]            rs,
    input  logic                  z,
    input  logic                  nega,
    input  logic                  int_req,
    input  logic                  int_en,
    output logic                  ir_we,
    output logic                  pc_we,
    output logic [1:0]            pcsource,
    output logic                  pc_exc,
    output logic                  wreg,
    output logic                  wmem,
    output logic                  mdu_start,
    output logic                  mdu_busy,
    output logic                  wlohi,
    output logic                  exc_we,
    output logic                  eret_pulse,
    output logic [EXC_CODE_W-1:0] cause,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MEM      = 3'd3,
        S_WB       = 3'd4,
        S_MDU_WAIT = 3'd5,
        S_EXC      = 3'd6
    } state_t;

    typedef enum logic [4:0] {
        C_NONE    = 5'd0,
        C_ALU     = 5'd1,
        C_LOAD    = 5'd2,
        C_STORE   = 5'd3,
        C_BEQ     = 5'd4,
        C_BNE     = 5'd5,
        C_BGEZ    = 5'd6,
        C_J       = 5'd7,
        C_JAL     = 5'd8,
        C_JR      = 5'd9,
        C_JALR    = 5'd10,
        C_MTLOHI  = 5'd11,
        C_MTC0    = 5'd12,
        C_MDU     = 5'd13,
        C_SYSCALL = 5'd14,
        C_BREAK   = 5'd15,
        C_TEQ     = 5'd16,
        C_ERET    = 5'd17
    } iclass_t;

    localparam logic [5:0] IMEM_LAST = 6'(IMEM_WAIT);
    localparam logic [5:0] DMEM_LAST = 6'(DMEM_WAIT);
    localparam logic [5:0] MDU_LAST  = 6'(MDU_LAT - 1);

    localparam logic [EXC_CODE_W-1:0] CAUSE_INT = EXC_CODE_W'(0);
    localparam logic [EXC_CODE_W-1:0] CAUSE_SYS = EXC_CODE_W'(8);
    localparam logic [EXC_CODE_W-1:0] CAUSE_BRK = EXC_CODE_W'(9);
    localparam logic [EXC_CODE_W-1:0] CAUSE_TEQ = EXC_CODE_W'(13);
`ifdef RI_EXC_EN
    localparam logic [EXC_CODE_W-1:0] CAUSE_RI  = EXC_CODE_W'(10);
`endif

    function automatic iclass_t decode_class(input logic [5:0] op_i,
                                             input logic [5:0] func_i,
                                             input logic [4:0] rs_i);
        iclass_t c;
        c = C_NONE;
        case (op_i)
            6'h00: begin
                case (func_i)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h10, 6'h12, 6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: c = C_ALU;
                    6'h08:                      c = C_JR;
                    6'h09:                      c = C_JALR;
                    6'h0C:                      c = C_SYSCALL;
                    6'h0D:                      c = C_BREAK;
                    6'h11, 6'h13:               c = C_MTLOHI;
                    6'h19, 6'h1A, 6'h1B:        c = C_MDU;
                    6'h34:                      c = C_TEQ;
                    default:                    c = C_NONE;
                endcase
            end
            6'h01: c = C_BGEZ;
            6'h02: c = C_J;
            6'h03: c = C_JAL;
            6'h04: c = C_BEQ;
            6'h05: c = C_BNE;
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F: c = C_ALU;
            6'h10: begin
                case (rs_i)
                    5'h00:   c = C_ALU;
                    5'h04:   c = C_MTC0;
                    5'h10:   c = (func_i == 6'h18) ? C_ERET : C_NONE;
                    default: c = C_NONE;
                endcase
            end
            6'h1C: c = ((func_i == 6'h02) || (func_i == 6'h20)) ? C_ALU : C_NONE;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: c = C_LOAD;
            6'h28, 6'h29, 6'h2B:               c = C_STORE;
            default: c = C_NONE;
        endcase
        return c;
    endfunction

    state_t                  state_r, next_s;
    logic [5:0]              cnt_r, cnt_nxt_s;
    logic [EXC_CODE_W-1:0]   cause_r, cause_nxt_s;
    iclass_t                 cls_s;
    logic                    ir_we_s, pc_we_s, pc_exc_s, wreg_s, wmem_s;
    logic                    mdu_start_s, mdu_busy_s, wlohi_s, exc_we_s, eret_s;
    logic [1:0]              pcsource_s;

    // State, shared wait/MDU counter and pending exception code.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
            cnt_r   <= 6'd0;
            cause_r <= {EXC_CODE_W{1'b0}};
        end else begin
            state_r <= next_s;
            cnt_r   <= cnt_nxt_s;
            cause_r <= cause_nxt_s;
        end
    end

    // Next-state and strobe decode from the state register and counter.
    always_comb begin
        next_s      = state_r;
        cnt_nxt_s   = 6'd0;
        cause_nxt_s = cause_r;
        cls_s       = decode_class(op, func, rs);
        ir_we_s     = 1'b0;
        pc_we_s     = 1'b0;
        pcsource_s  = 2'b00;
        pc_exc_s    = 1'b0;
        wreg_s      = 1'b0;
        wmem_s      = 1'b0;
        mdu_start_s = 1'b0;
        mdu_busy_s  = 1'b0;
        wlohi_s     = 1'b0;
        exc_we_s    = 1'b0;
        eret_s      = 1'b0;
        case (state_r)
            S_FETCH: begin
                // Interrupts are only taken on FETCH entry, so none is lost mid-instruction.
                if ((cnt_r == 6'd0) && int_req && int_en) begin
                    next_s      = S_EXC;
                    cause_nxt_s = CAUSE_INT;
                end else if (cnt_r == IMEM_LAST) begin
                    ir_we_s = 1'b1;
                    pc_we_s = 1'b1;
                    next_s  = S_DECODE;
                end else begin
                    cnt_nxt_s = cnt_r + 6'd1;
                end
            end
            S_DECODE: begin
                if (cls_s == C_NONE) begin
`ifdef RI_EXC_EN
                    next_s      = S_EXC;
                    cause_nxt_s = CAUSE_RI;
`else
                    next_s      = S_FETCH;
`endif
                end else begin
                    next_s = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_s)
                    C_ALU:    next_s = S_WB;
                    C_LOAD:   next_s = S_MEM;
                    C_STORE:  next_s = S_MEM;
                    C_BEQ:    begin pc_we_s = z;     pcsource_s = 2'b01; next_s = S_FETCH; end
                    C_BNE:    begin pc_we_s = ~z;    pcsource_s = 2'b01; next_s = S_FETCH; end
                    C_BGEZ:   begin pc_we_s = ~nega; pcsource_s = 2'b01; next_s = S_FETCH; end
                    C_J:      begin pc_we_s = 1'b1;  pcsource_s = 2'b11; next_s = S_FETCH; end
                    C_JAL:    begin pc_we_s = 1'b1;  pcsource_s = 2'b11; next_s = S_WB;    end
                    C_JR:     begin pc_we_s = 1'b1;  pcsource_s = 2'b10; next_s = S_FETCH; end
                    C_JALR:   begin pc_we_s = 1'b1;  pcsource_s = 2'b10; next_s = S_WB;    end
                    C_MTLOHI: begin wlohi_s = 1'b1;  next_s = S_FETCH; end
                    C_MTC0:   next_s = S_FETCH;
                    C_MDU:    begin mdu_start_s = 1'b1; next_s = S_MDU_WAIT; end
                    C_SYSCALL: begin next_s = S_EXC; cause_nxt_s = CAUSE_SYS; end
                    C_BREAK:   begin next_s = S_EXC; cause_nxt_s = CAUSE_BRK; end
                    C_TEQ: begin
                        if (z) begin
                            next_s      = S_EXC;
                            cause_nxt_s = CAUSE_TEQ;
                        end else begin
                            next_s = S_FETCH;
                        end
                    end
                    C_ERET: begin
                        eret_s   = 1'b1;
                        pc_we_s  = 1'b1;
                        pc_exc_s = 1'b1;
                        next_s   = S_FETCH;
                    end
                    default: next_s = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (cnt_r == DMEM_LAST) begin
                    if (cls_s == C_STORE) begin
                        wmem_s = 1'b1;
                        next_s = S_FETCH;
                    end else begin
                        next_s = S_WB;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + 6'd1;
                end
            end
            S_WB: begin
                wreg_s = 1'b1;
                next_s = S_FETCH;
            end
            S_MDU_WAIT: begin
                mdu_busy_s = 1'b1;
                if (cnt_r == MDU_LAST) begin
                    wlohi_s = 1'b1;
                    next_s  = S_FETCH;
                end else begin
                    cnt_nxt_s = cnt_r + 6'd1;
                end
            end
            S_EXC: begin
                exc_we_s = 1'b1;
                pc_we_s  = 1'b1;
                pc_exc_s = 1'b1;
                next_s   = S_FETCH;
            end
            default: next_s = S_FETCH;
        endcase
    end

    // Reset masks every strobe in the same cycle, so an aborted MEM/MDU_WAIT commits nothing.
    assign ir_we      = ir_we_s & ~rst;
    assign pc_we      = pc_we_s & ~rst;
    assign pcsource   = pcsource_s & {2{~rst}};
    assign pc_exc     = pc_exc_s & ~rst;
    assign wreg       = wreg_s & ~rst;
    assign wmem       = wmem_s & ~rst;
    assign mdu_start  = mdu_start_s & ~rst;
    assign mdu_busy   = mdu_busy_s & ~rst;
    assign wlohi      = wlohi_s & ~rst;
    assign exc_we     = exc_we_s & ~rst;
    assign eret_pulse = eret_s & ~rst;
    assign cause      = ((state_r == S_EXC) && !rst) ? cause_r : {EXC_CODE_W{1'b0}};
    assign state      = state_r;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multi-cycle sequencing controller for the 54-instruction MIPS core; it is the successor to the single-cycle decoder. It decodes the same op/func/rs fields and steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It adds parametrised memory wait-states, a multi-cycle MDU wait, and precise exception and interrupt entry. It drives the one-cycle write strobes and the PC update for the datapath; datapath mux selects stay with the datapath decoder.

Parameters:
IMEM_WAIT, 0, extra FETCH cycles before the instruction is valid (0..15)
DMEM_WAIT, 0, extra MEM cycles for loads/stores (0..15)
MDU_LAT, 32, cycles spent in MDU_WAIT for div/divu/multu (1..63)
EXC_CODE_W, 5, width of cause

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
op  in  6  IR[31:26], valid from DECODE onward
func  in  6  IR[5:0]
rs  in  5  IR[25:21]
z  in  1  ALU zero flag, valid in EXEC
nega  in  1  ALU negative flag, valid in EXEC
int_req  in  1  external interrupt, level-sensitive
int_en  in  1  CP0 status interrupt enable
ir_we  out  1  latch instruction register
pc_we  out  1  PC write strobe
pcsource  out  2  00 PC+4, 01 branch target, 10 rs register, 11 jump target
pc_exc  out  1  PC takes exception vector (or EPC when eret_pulse=1)
wreg  out  1  regfile write strobe
wmem  out  1  data memory write strobe
mdu_start  out  1  one-cycle MDU launch
mdu_busy  out  1  high throughout MDU_WAIT
wlohi  out  1  LO/HI write strobe
exc_we  out  1  commit EPC/cause/status
eret_pulse  out  1  eret commit
cause  out  EXC_CODE_W  exception code, valid while exc_we=1
state  out  3  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDU_WAIT=5, EXC=6. rst forces FETCH and clears the wait and MDU counters. While rst=1 all strobes are 0 and cause=0.
- Strobes are single-cycle and decoded from the state register plus the latched wait counter.
- FETCH: the wait counter runs for IMEM_WAIT cycles. On the final cycle ir_we=1, pc_we=1 and pcsource=00, then go to DECODE.
- Interrupt check happens on the first FETCH cycle only. If int_req&int_en, go to EXC with cause=0. No fetch occurs and the PC is not advanced.
- DECODE → EXEC for every recognised instruction. Unrecognised encodings return to FETCH as a NOP.
- EXEC actions by instruction class:
  - ALU, shift, mul, clz, mfhi/mflo, mfc0: → WB (4 cycles total).
  - lw/lh/lhu/lb/lbu: → MEM → WB (5+DMEM_WAIT cycles).
  - sw/sh/sb: → MEM, with wmem on the last MEM cycle, then FETCH.
  - beq/bne/bgez: pc_we = condition taken (z / ~z / ~nega), pcsource=01, → FETCH (3 cycles).
  - j: pc_we, pcsource=11, → FETCH.
  - jal: pc_we, pcsource=11, → WB.
  - jr: pcsource=10, → FETCH.
  - jalr: pcsource=10, → WB.
  - mthi/mtlo/mtc0: wlohi (mthi/mtlo only) or the CP0 write in EXEC, → FETCH.
  - div/divu/multu: mdu_start=1, → MDU_WAIT.
  - syscall, break, teq with z=1: → EXC.
  - teq with z=0: → FETCH.
  - eret: eret_pulse=1, pc_we=1, pc_exc=1, → FETCH.
- MEM: lasts 1+DMEM_WAIT cycles.
- WB: wreg=1, → FETCH.
- MDU_WAIT: lasts exactly MDU_LAT cycles with mdu_busy=1. wlohi=1 on the final cycle, then FETCH.
- EXC: one cycle with exc_we=1, pc_we=1, pc_exc=1, then FETCH.
- Cause codes: interrupt 0, syscall 8, break 9, teq 13.
- An interrupt asserted during MDU_WAIT or a multi-cycle MEM is deferred to the next FETCH entry, never dropped while still asserted.
- rst during MDU_WAIT or MEM: immediate return to FETCH with no wlohi and no wmem that cycle.
- Never more than one of wreg, wmem, wlohi or exc_we in the same cycle.

Optional Feature:
RI_EXC_EN
- Defined: an unrecognised encoding goes DECODE → EXC with cause=10 (reserved instruction).
- Undefined: the encoding is a 2-cycle NOP and cause never equals 10.

Test Plan:
- addu after reset, IMEM_WAIT=0 → ir_we cycle 0, wreg cycle 3, state=FETCH cycle 4; DMEM_WAIT=2, lw → wreg cycle 6.
- beq with z=1 → pc_we and pcsource=01 in cycle 2. With z=0 → no pc_we in EXEC. bgez with nega=1 → not taken.
- divu, MDU_LAT=8 → mdu_start cycle 2, mdu_busy cycles 3–10, wlohi cycle 10 only, FETCH cycle 11.
- syscall → exc_we, pc_exc and cause=8 in cycle 3. teq with z=1 → cause=13. teq with z=0 → no exc_we.
- int_req=1, int_en=1 raised during MDU_WAIT → no effect until FETCH. Then EXC with cause=0 and no ir_we. With int_en=0 → normal fetch.
- rst pulsed mid-MDU_WAIT → state=FETCH next cycle, wlohi never asserted, all strobes 0 while rst=1.
